des_key_sched: RTL and testbench

// Sequential DES key schedule: accepts a 64-bit key, streams round subkeys K1..Kn
// (encrypt) or Kn..K1 (decrypt) over valid/ready. Producer side of the round

---
 rtl/des_key_sched.sv | 193 +++++++++++++++++++
 tb/tb_des_key_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - sequential DES key schedule streaming round subkeys over valid/ready
// Optional key parity check: DES_KEY_SCHED_PARITY_CHK_EN
module des_key_sched #(
    parameter int ROUNDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [47:0] subkey_o,
    output logic [3:0]  round_o,
    output logic        last_o,
    output logic        busy_o,
    output logic        parity_err_o
);

    // DES bit numbering is 1-based from the MSB: DES bit n of the key is key_i[64-n].
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Per-round left-rotation amount, round n in 1..16.
    function automatic logic [4:0] shift_amt(input logic [4:0] n);
        return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 5'd1 : 5'd2;
    endfunction

    function automatic int cum_shift(input int n);
        int s;
        s = 0;
        for (int i = 1; i <= n; i++) begin
            s += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
        end
        return s;
    endfunction

    // Decrypt starts from the CD of the final round; for 16 rounds this wraps to 0.
    localparam logic [4:0] DEC_ROT  = 5'(cum_shift(ROUNDS) % 28);
    localparam logic [4:0] ENC_ROT  = 5'd1;
    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    // C occupies cd[55:28] (C bit 1 at cd[55]), D occupies cd[27:0].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
        return (x << n) | (x >> (5'd28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
        return (x >> n) | (x << (5'd28 - n));
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] x, input logic [4:0] n);
        return {rotl28(x[55:28], n), rotl28(x[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] x, input logic [4:0] n);
        return {rotr28(x[55:28], n), rotr28(x[27:0], n)};
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [55:0] cd_q;
    logic [3:0]  count_q;
    logic        dec_q;
    logic        key_par_ok;
    logic        key_fire;
    logic        sub_fire;

    assign key_fire = key_valid_i & key_ready_o & key_par_ok;
    assign sub_fire = subkey_valid_o & subkey_ready_i;

`ifdef DES_KEY_SCHED_PARITY_CHK_EN
    logic parity_err_q;

    // Every key byte must carry odd parity for the key to be accepted.
    always_comb begin
        key_par_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (^key_i[b*8 +: 8] == 1'b0) begin
                key_par_ok = 1'b0;
            end
        end
    end

    // One-cycle error pulse following a rejected key handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= key_valid_i & key_ready_o & ~key_par_ok;
        end
    end

    assign parity_err_o = parity_err_q;
`else
    logic unused_key_parity;

    assign key_par_ok        = 1'b1;
    assign parity_err_o      = 1'b0;
    assign unused_key_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                                 key_i[24], key_i[16], key_i[8],  key_i[0]};
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one key at a time, back to IDLE after the final subkey is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_fire) state_d = EMIT;
            EMIT:    if (sub_fire && last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: subkey fields are forced to zero whenever no subkey is on offer.
    always_comb begin
        key_ready_o    = (state_q == IDLE);
        subkey_valid_o = (state_q == EMIT);
        busy_o         = (state_q == EMIT);
        subkey_o       = '0;
        round_o        = '0;
        last_o         = 1'b0;
        if (state_q == EMIT) begin
            subkey_o = pc2(cd_q);
            round_o  = dec_q ? (LAST_CNT - count_q) : count_q;
            last_o   = (count_q == LAST_CNT);
        end
    end

    // C/D rotation and round counter; CD only advances on a subkey handshake so stalls hold output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cd_q    <= '0;
            count_q <= '0;
            dec_q   <= 1'b0;
        end else if (key_fire) begin
            count_q <= '0;
            dec_q   <= decrypt_i;
            cd_q    <= decrypt_i ? rotl_cd(pc1(key_i), DEC_ROT) : rotl_cd(pc1(key_i), ENC_ROT);
        end else if (sub_fire && !last_o) begin
            count_q <= count_q + 4'd1;
            if (dec_q) begin
                cd_q <= rotr_cd(cd_q, shift_amt(5'(ROUNDS) - {1'b0, count_q}));
            end else begin
                cd_q <= rotl_cd(cd_q, shift_amt({1'b0, count_q} + 5'd2));
            end
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - self-checking bench for des_key_sched against a table-driven key schedule model
module tb_des_key_sched;

    localparam int ROUNDS = 16;
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] BAD_KEY = 64'h133457799BBCDFF0;
    localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        last;
    logic        busy;
    logic        parity_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    des_key_sched #(.ROUNDS(ROUNDS)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .key_valid_i    (key_valid),
        .key_ready_o    (key_ready),
        .key_i          (key),
        .decrypt_i      (decrypt),
        .subkey_valid_o (subkey_valid),
        .subkey_ready_i (subkey_ready),
        .subkey_o       (subkey),
        .round_o        (round),
        .last_o         (last),
        .busy_o         (busy),
        .parity_err_o   (parity_err)
    );

    // Subkey of DES round r (1-based): C0/D0 rotated left by the cumulative shift, then PC2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
        logic        kb [1:64];
        logic        c [0:27];
        logic        d [0:27];
        logic        cd [1:56];
        logic [47:0] res;
        int          s;
        for (int n = 1; n <= 64; n++) kb[n] = k[64 - n];
        for (int i = 0; i < 28; i++) begin
            c[i] = kb[PC1_T[i]];
            d[i] = kb[PC1_T[28 + i]];
        end
        s = 0;
        for (int i = 0; i < r; i++) s += SHIFTS[i];
        for (int i = 0; i < 28; i++) begin
            cd[i + 1]  = c[(i + s) % 28];
            cd[i + 29] = d[(i + s) % 28];
        end
        for (int j = 0; j < 48; j++) res[47 - j] = cd[PC2_T[j]];
        return res;
    endfunction

    function automatic logic [63:0] fix_parity(input logic [63:0] k);
        logic [63:0] r;
        r = k;
        for (int b = 0; b < 8; b++) begin
            if (^r[b*8 +: 8] == 1'b0) r[b*8] = ~r[b*8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_valid = 1'b0;
        key = '0;
        decrypt = 1'b0;
        subkey_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || subkey !== 48'h0 || round !== 4'h0 ||
            last !== 1'b0 || busy !== 1'b0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b sk=%h rnd=%0d last=%b busy=%b perr=%b required 1 0 0 0 0 0 0",
                     key_ready, subkey_valid, subkey, round, last, busy, parity_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: rdy=%b vld=%b required 1 0", key_ready, subkey_valid);
        end
    endtask

    // One full key: handshake, then every subkey checked each cycle (stalls included) against the model.
    task automatic test_stream(input logic [63:0] k, input logic dec, input int stall_pct,
                               output logic [47:0] first_sk, output logic [47:0] last_sk);
        int          idx;
        int          cyc;
        int          exp_r;
        logic        fire;
        logic [47:0] exp_sk;
        first_sk = 'x;
        last_sk  = 'x;
        cyc = 0;
        while (key_ready !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_wait_ready: key_ready_o=%b required 1", key_ready);
            return;
        end
        key_valid = 1'b1;
        key = k;
        decrypt = dec;
        tick();
        key_valid = 1'b0;
        key = {$urandom, $urandom};
        decrypt = 1'($urandom_range(1));
        checks++;
        if (subkey_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_latency: subkey_valid_o=%b required 1 one cycle after key handshake", subkey_valid);
        end
        idx = 0;
        cyc = 0;
        while (idx < ROUNDS && cyc < 4000) begin
            subkey_ready = ($urandom_range(99) >= stall_pct);
            exp_r  = dec ? (ROUNDS - idx) : (idx + 1);
            exp_sk = ref_subkey(k, exp_r);
            checks++;
            if (subkey_valid !== 1'b1 || subkey !== exp_sk || round !== 4'(exp_r - 1) ||
                last !== (idx == ROUNDS - 1) || busy !== 1'b1 || key_ready !== 1'b0 || parity_err !== 1'b0) begin
                errors++;
                $display("FAIL stream_subkey idx=%0d: vld=%b sk=%h rnd=%0d last=%b busy=%b rdy=%b perr=%b required 1 %h %0d %b 1 0 0",
                         idx, subkey_valid, subkey, round, last, busy, key_ready, parity_err,
                         exp_sk, exp_r - 1, (idx == ROUNDS - 1));
            end
            if (idx == 0) first_sk = subkey;
            if (idx == ROUNDS - 1) last_sk = subkey;
            fire = subkey_ready;
            tick();
            if (fire) idx++;
            cyc++;
        end
        subkey_ready = 1'b0;
        checks++;
        if (idx != ROUNDS) begin
            errors++;
            $display("FAIL stream_timeout: consumed %0d subkeys required %0d", idx, ROUNDS);
        end
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || subkey !== 48'h0 || round !== 4'h0 ||
            last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle_after: vld=%b rdy=%b sk=%h rnd=%0d last=%b busy=%b required 0 1 0 0 0 0",
                     subkey_valid, key_ready, subkey, round, last, busy);
        end
    endtask

    task automatic test_known_vectors();
        logic [47:0] f;
        logic [47:0] l;
        test_stream(KAT_KEY, 1'b0, 0, f, l);
        checks++;
        if (f !== KAT_K1 || l !== KAT_K16) begin
            errors++;
            $display("FAIL kat_encrypt: first=%h last=%h required %h %h", f, l, KAT_K1, KAT_K16);
        end
        test_stream(KAT_KEY, 1'b1, 0, f, l);
        checks++;
        if (f !== KAT_K16 || l !== KAT_K1) begin
            errors++;
            $display("FAIL kat_decrypt: first=%h last=%h required %h %h", f, l, KAT_K16, KAT_K1);
        end
    endtask

    task automatic test_stall();
        logic [47:0] f;
        logic [47:0] l;
        test_stream(KAT_KEY, 1'b0, 50, f, l);
        checks++;
        if (f !== KAT_K1 || l !== KAT_K16) begin
            errors++;
            $display("FAIL stall_kat: first=%h last=%h required %h %h", f, l, KAT_K1, KAT_K16);
        end
        for (int i = 0; i < 3; i++) begin
            test_stream(fix_parity({$urandom, $urandom}), 1'($urandom_range(1)), 50, f, l);
        end
    endtask

    task automatic test_random_keys();
        logic [47:0] f;
        logic [47:0] l;
        for (int i = 0; i < 6; i++) begin
            test_stream(fix_parity({$urandom, $urandom}), 1'($urandom_range(1)), (i % 2) * 30, f, l);
        end
    endtask

    // Key valid held high across a whole stream: second key lands only after a one-cycle bubble.
    task automatic test_back_to_back();
        logic [63:0] kb;
        kb = fix_parity({$urandom, $urandom});
        subkey_ready = 1'b1;
        key_valid = 1'b1;
        key = KAT_KEY;
        decrypt = 1'b0;
        tick();
        key = kb;
        for (int i = 0; i < ROUNDS; i++) begin
            checks++;
            if (subkey_valid !== 1'b1 || key_ready !== 1'b0 || subkey !== ref_subkey(KAT_KEY, i + 1)) begin
                errors++;
                $display("FAIL b2b_first_key idx=%0d: vld=%b rdy=%b sk=%h required 1 0 %h",
                         i, subkey_valid, key_ready, subkey, ref_subkey(KAT_KEY, i + 1));
            end
            tick();
        end
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bubble: vld=%b rdy=%b required 0 1", subkey_valid, key_ready);
        end
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < ROUNDS; i++) begin
            checks++;
            if (subkey_valid !== 1'b1 || subkey !== ref_subkey(kb, i + 1) || round !== 4'(i)) begin
                errors++;
                $display("FAIL b2b_second_key idx=%0d: vld=%b sk=%h rnd=%0d required 1 %h %0d",
                         i, subkey_valid, subkey, round, ref_subkey(kb, i + 1), i);
            end
            tick();
        end
        subkey_ready = 1'b0;
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_after: vld=%b rdy=%b required 0 1", subkey_valid, key_ready);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [47:0] f;
        logic [47:0] l;
        subkey_ready = 1'b1;
        key_valid = 1'b1;
        key = KAT_KEY;
        decrypt = 1'b0;
        tick();
        key_valid = 1'b0;
        repeat (7) tick();
        checks++;
        if (round !== 4'd7 || subkey !== ref_subkey(KAT_KEY, 8)) begin
            errors++;
            $display("FAIL midrst_before: rnd=%0d sk=%h required 7 %h", round, subkey, ref_subkey(KAT_KEY, 8));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || subkey !== 48'h0 || round !== 4'h0 ||
            last !== 1'b0 || busy !== 1'b0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: rdy=%b vld=%b sk=%h rnd=%0d last=%b busy=%b perr=%b required 1 0 0 0 0 0 0",
                     key_ready, subkey_valid, subkey, round, last, busy, parity_err);
        end
        subkey_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_no_resume: vld=%b rdy=%b required 0 1", subkey_valid, key_ready);
        end
        test_stream(KAT_KEY, 1'b0, 0, f, l);
        checks++;
        if (f !== KAT_K1) begin
            errors++;
            $display("FAIL midrst_restart: first=%h required %h", f, KAT_K1);
        end
    endtask

    task automatic test_parity();
        logic [47:0] f;
        logic [47:0] l;
`ifdef DES_KEY_SCHED_PARITY_CHK_EN
        key_valid = 1'b1;
        key = BAD_KEY;
        decrypt = 1'b0;
        tick();
        key_valid = 1'b0;
        checks++;
        if (parity_err !== 1'b1 || subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL parity_pulse: perr=%b vld=%b rdy=%b required 1 0 1", parity_err, subkey_valid, key_ready);
        end
        tick();
        checks++;
        if (parity_err !== 1'b0 || subkey_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_pulse_end: perr=%b vld=%b required 0 0", parity_err, subkey_valid);
        end
        test_stream(KAT_KEY, 1'b0, 0, f, l);
        checks++;
        if (f !== KAT_K1 || l !== KAT_K16) begin
            errors++;
            $display("FAIL parity_good_key: first=%h last=%h required %h %h", f, l, KAT_K1, KAT_K16);
        end
`else
        test_stream(BAD_KEY, 1'b0, 0, f, l);
        checks++;
        if (f !== KAT_K1 || l !== KAT_K16 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_ignored: first=%h last=%h perr=%b required %h %h 0", f, l, parity_err, KAT_K1, KAT_K16);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_stall();
        test_random_keys();
        test_back_to_back();
        test_reset_mid_stream();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
